// File: rtl/bit_serial_adder.sv
// bit_serial_adder: multi-cycle WIDTH-bit adder built around a single
// one_bit_full_adder. Operands are shifted out LSB first, one bit per clock,
// and the sum bits are shifted into the result register from the top.
//
// Handshake: start is accepted on any rising edge where busy=0 (IDLE or
// DONE); start while busy=1 is dropped, not queued. busy is high for WIDTH
// cycles after the accepting edge; done then pulses for exactly one cycle,
// and sum/c_out/overflow stay valid until the next accepted start.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   start      add request (sampled only when busy=0)
//   a, b       WIDTH-bit operands, captured on the accepting edge
//   c_in       carry-in, captured on the accepting edge
//   busy       high while bits are being processed
//   done       one-cycle completion pulse
//   sum        WIDTH-bit result register
//   c_out      carry out of bit WIDTH-1
//   overflow   signed overflow flag (0 unless BIT_SERIAL_ADDER_OVERFLOW_EN)
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Configuration macro: BIT_SERIAL_ADDER_OVERFLOW_EN builds the overflow
// register; when undefined the overflow port is tied to 0.

module one_bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic [1:0]       dbg_state
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    logic fa_sum;
    logic fa_cout;
    logic accept;
    logic last_bit;

    one_bit_full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // A request is only seen outside RUN; DONE accepts directly so a held
    // start runs back-to-back without an IDLE cycle.
    assign accept   = start && (state_q != RUN);
    assign last_bit = (state_q == RUN) && (count_q == LAST_BIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    // New sum bit enters at the MSB; after WIDTH shifts bit 0
                    // of the operands has reached sum[0].
                    sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    count_q <= count_q + CNT_W'(1);
                    if (last_bit) begin
                        c_out_q <= fa_cout;
                        state_q <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= c_in;
                        count_q <= '0;
                        sum_q   <= '0;
                        c_out_q <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        // DONE falls back to IDLE; results are held.
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    logic overflow_q;

    // On the last bit carry_q is the carry into the MSB and fa_cout the
    // carry out of it; their XOR is the two's-complement overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (accept) begin
            overflow_q <= 1'b0;
        end else if (last_bit) begin
            overflow_q <= carry_q ^ fa_cout;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign dbg_state = state_q;

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Multi-cycle adder that produces a WIDTH-bit sum one bit per clock by driving a single `one_bit_full_adder` instance from two operand shift registers and a registered carry. It sits directly downstream of the one-bit full adder and consumes its `sum`/`c_out` every cycle. It gives the LEGv8 datapath an area-minimal ADD/ADDS path, started by a one-cycle request and finished by a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 64: operand and sum width in bits, minimum 2.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request an add; sampled only when `busy`=0.
- `a` in WIDTH: operand A; captured on the accepted `start` edge.
- `b` in WIDTH: operand B; captured on the accepted `start` edge.
- `c_in` in 1: carry-in; captured on the accepted `start` edge.
- `busy` out 1: high while bits are being processed.
- `done` out 1: one-cycle pulse; `sum`, `c_out` and `overflow` are valid from this cycle on.
- `sum` out WIDTH: result register.
- `c_out` out 1: carry out of bit WIDTH-1.
- `overflow` out 1: signed overflow flag (see Configuration).

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- IDLE or DONE with `start`=1 → RUN.
  - Load the operand shift registers with `a` and `b`.
  - Load the carry flop with `c_in`.
  - Clear the bit counter to 0.
  - Clear `sum`, `c_out` and `overflow` to 0.
- DONE with `start`=0 → IDLE. `sum`, `c_out` and `overflow` hold their values.
- Each RUN edge processes the bit selected by the counter, LSB first:
  - Drive the full adder from the operand shift-register LSBs and the carry flop.
  - Shift the adder's `sum` bit into `sum[WIDTH-1]`, moving the previous `sum` bits right.
  - Load the carry flop from the adder's `c_out`.
  - Shift both operand registers right by one.
  - Increment the counter.
- On the RUN edge with counter = WIDTH-1:
  - Load `c_out` from the adder's carry-out.
  - Load `overflow` from (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - Go to DONE.
- `start` while `busy`=1 is ignored. It is not queued, and the operands are not re-sampled.
- Arithmetic is modulo 2^WIDTH. After DONE, {`c_out`, `sum`} = `a` + `b` + `c_in`, exactly.
- Counter width is ceil(log2(WIDTH)); it never wraps inside RUN.

## Timing
- The `start` edge is edge 0. `busy` rises after edge 0 and stays high for WIDTH cycles.
- Edge WIDTH moves the block to DONE. `done` is high for exactly the cycle after edge WIDTH.
- Latency from accepted `start` to `done` is WIDTH+1 edges including the start edge, i.e. WIDTH processing cycles. The input side can accept a new start every WIDTH+1 cycles.
- `start` held high through DONE is accepted back-to-back: DONE→RUN directly, with no IDLE cycle, and `done` still pulses for one cycle.
- Reset, asynchronous at any time including mid-RUN:
  - State returns to IDLE; counter and carry flop clear to 0.
  - `busy`=0, `done`=0, `sum`=0, `c_out`=0, `overflow`=0.
  - The partial result is discarded.
- Reset and `start` on the same edge: reset wins.
- Outputs are registered only; no combinational path runs from inputs to outputs.

## Configuration
- `BIT_SERIAL_ADDER_OVERFLOW_EN` defined:
  - The carry-into-MSB tap and `overflow` register are built.
  - `overflow` updates on the final RUN edge as described in Operation.
- Not defined:
  - No overflow logic is built and `overflow` is tied to 0.
  - The port still exists, so instantiations are unchanged.

## Test plan
- WIDTH=8, `reset` pulsed mid-RUN after 3 bits → immediately `busy`=0, `done`=0, `sum`=0x00, `c_out`=0; a following start of 0x01+0x01 gives `sum`=0x02.
- WIDTH=8, a=0x0F, b=0x01, c_in=0 → `done` exactly 9 edges after start (WIDTH+1), `sum`=0x10, `c_out`=0, `overflow`=0.
- WIDTH=8, a=0xFF, b=0x00, c_in=1 → `sum`=0x00, `c_out`=1, `overflow`=0; with the macro undefined, `overflow` stays 0 in every scenario.
- WIDTH=8, a=0x7F, b=0x01, c_in=0, macro defined → `sum`=0x80, `c_out`=0, `overflow`=1.
- WIDTH=8, `start` pulsed again at bit 4 with a=0x33 → ignored; the original 0x12+0x34 gives `sum`=0x46. Then `start` held high through DONE with 0x01+0x02 → the next RUN begins with no IDLE cycle and gives `sum`=0x03.
- WIDTH=64, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, c_in=0 → `done` after 64 processing cycles, `sum`=0, `c_out`=1, `overflow`=0.
